// File: rtl/dmem_resp.sv
// dmem_resp: single-cycle data memory with byte lanes plus cycle/console/status MMIO window
module dmem_resp #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [1:0]  fault
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  logic [31:0] ram [DEPTH];
  logic [31:0] cyc_q, cyc_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [1:0]  fault_q, fault_d;
  logic        is_ram, is_mmio, sz_b, sz_h, sz_w, mis, st, ram_we, cyc_wr, con_wr, bad, misf;
  logic [1:0]  off, clr;
  logic [AW-1:0] idx;
  logic [31:0] word, wrep, wmerge, mmio_rd;
  logic [3:0]  be;
  logic [7:0]  lb;
  logic [15:0] lh;

  // address decode, lane selection and store-data merge into the addressed word
  always_comb begin
    is_ram  = addr < RAM_BYTES;
    is_mmio = addr[31:4] == MMIO_BASE[31:4];
    off     = addr[3:2];
    sz_b    = memsize[1:0] == 2'b00;
    sz_h    = memsize[1:0] == 2'b01;
    sz_w    = !sz_b && !sz_h;
    mis     = (sz_h && addr[0]) || (sz_w && |addr[1:0]);
    idx     = addr[AW+1:2];
    word    = ram[idx];
    lb      = word[{addr[1:0], 3'b000} +: 8];
    lh      = addr[1] ? word[31:16] : word[15:0];
    be      = sz_b ? 4'b0001 << addr[1:0] : sz_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep    = sz_b ? {4{writedata[7:0]}} : sz_h ? {2{writedata[15:0]}} : writedata;
    wmerge  = word;
    for (int i = 0; i < 4; i++) wmerge[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word[8*i +: 8];
  end

  // combinational load path; MMIO returns full register words regardless of size
  always_comb begin
    mmio_rd  = off == 2'd0 ? cyc_q : off == 2'd1 ? {24'b0, tx_data_q} : off == 2'd2 ? {30'b0, fault_q} : 32'b0;
    readdata = is_mmio ? mmio_rd :
               (!is_ram || mis) ? 32'b0 :
               sz_b ? {{24{lb[7] & ~memsize[2]}}, lb} :
               sz_h ? {{16{lh[15] & ~memsize[2]}}, lh} : word;
  end

  // store side effects: RAM enable, register updates and fault accumulation
  always_comb begin
    st         = memwrite && !mis;
    ram_we     = st && is_ram && !is_mmio;
    cyc_wr     = st && is_mmio && off == 2'd0 && sz_w;
    con_wr     = st && is_mmio && off == 2'd1;
    clr        = (st && is_mmio && off == 2'd2 && sz_w) ? writedata[1:0] : 2'b00;
    misf       = memwrite && mis && (is_ram || is_mmio);
    bad        = memwrite && ((!is_mmio && !is_ram) || (!mis && is_mmio && (off == 2'd3 || (off != 2'd1 && !sz_w))));
    fault_d    = (fault_q & ~clr) | {bad, misf};
    cyc_d      = cyc_wr ? writedata : cyc_q + 32'd1;
    tx_valid_d = con_wr;
    tx_data_d  = con_wr ? writedata[7:0] : tx_data_q;
  end

  // register state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      fault_q    <= '0;
    end else begin
      cyc_q      <= cyc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      fault_q    <= fault_d;
    end
  end

  // whole-word RAM write so a store is either fully committed or dropped under reset
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[idx] <= wmerge;
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign fault    = fault_q;
endmodule
